// File: rtl/noc_rr_arbiter_if.sv
// Switch-allocator bundle: FIFO heads and downstream flow control in, pops and output-stage writes out.
// The slave modport is the arbiter; the master modport is the FIFO/output-stage side.
interface noc_rr_arbiter_if #(
    parameter int unsigned WIDTH = 16
);
    logic             emptyE;
    logic             emptyW;
    logic             emptyL;
    logic [WIDTH-1:0] dataInE;
    logic [WIDTH-1:0] dataInW;
    logic [WIDTH-1:0] dataInL;
    logic             readFullE;
    logic             readFullW;
    logic             readFullL;
    logic             read_almostfullE;
    logic             read_almostfullW;
    logic             read_almostfullL;
    logic             readE;
    logic             readW;
    logic             readL;
    logic             writeOutE;
    logic             writeOutW;
    logic             writeOutL;
    logic [WIDTH-1:0] dataOutE;
    logic [WIDTH-1:0] dataOutW;
    logic [WIDTH-1:0] dataOutL;
    logic [2:0]       starved;

    modport master (
        output emptyE, emptyW, emptyL, dataInE, dataInW, dataInL,
        output readFullE, readFullW, readFullL,
        output read_almostfullE, read_almostfullW, read_almostfullL,
        input  readE, readW, readL, writeOutE, writeOutW, writeOutL,
        input  dataOutE, dataOutW, dataOutL, starved
    );

    modport slave (
        input  emptyE, emptyW, emptyL, dataInE, dataInW, dataInL,
        input  readFullE, readFullW, readFullL,
        input  read_almostfullE, read_almostfullW, read_almostfullL,
        output readE, readW, readL, writeOutE, writeOutW, writeOutL,
        output dataOutE, dataOutW, dataOutL, starved
    );
endinterface

// File: rtl/noc_rr_arbiter.sv
// Three-port (E, W, L) NoC switch allocator: combinational grants per output port using
// round-robin with a lowest-index starvation override; pointers and wait counters are registered.
module noc_rr_arbiter #(
    parameter int unsigned WIDTH      = 16,
    parameter logic [1:0]  LOCAL_IP   = 2'b00,
    parameter int unsigned STARVE_LIM = 4
) (
    input logic             clk,
    input logic             rst,
    noc_rr_arbiter_if.slave bus
);
    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    // Index order everywhere: E=0, W=1, L=2 (both inputs and outputs).
    logic [2:0]       w_empty;
    logic [WIDTH-1:0] w_head [3];
    logic [2:0]       w_elig;
    logic [1:0]       w_route [3];
    logic [2:0]       w_req [3];
    logic [2:0]       w_stv;
    logic [2:0]       w_gnt [3];
    logic [2:0]       w_granted;
    logic [WIDTH-1:0] w_dout [3];
    logic [1:0]       r_ptr [3];
    logic [3:0]       r_wait [3];

    function automatic logic [1:0] route(input logic [WIDTH-1:0] flit);
        logic [1:0] d;
        d = flit[WIDTH-1 -: 2];
        if (d == LOCAL_IP) begin
            route = 2'd2;
        end else if (d > LOCAL_IP) begin
            route = 2'd0;
        end else begin
            route = 2'd1;
        end
    endfunction

    function automatic logic [2:0] pick(input logic [2:0] req, input logic [2:0] stv,
                                        input logic [1:0] ptr);
        logic [2:0] hit;
        hit = req & stv;
        if (hit != 3'b000) begin
            pick = hit[0] ? 3'b001 : (hit[1] ? 3'b010 : 3'b100);
        end else begin
            case (ptr)
                2'd1:    pick = req[1] ? 3'b010 : (req[2] ? 3'b100 : (req[0] ? 3'b001 : 3'b000));
                2'd2:    pick = req[2] ? 3'b100 : (req[0] ? 3'b001 : (req[1] ? 3'b010 : 3'b000));
                default: pick = req[0] ? 3'b001 : (req[1] ? 3'b010 : (req[2] ? 3'b100 : 3'b000));
            endcase
        end
    endfunction

    function automatic logic [1:0] next_ptr(input logic [2:0] gnt);
        case (gnt)
            3'b001:  next_ptr = 2'd1;
            3'b010:  next_ptr = 2'd2;
            default: next_ptr = 2'd0;
        endcase
    endfunction

    assign w_empty   = {bus.emptyL, bus.emptyW, bus.emptyE};
    assign w_head[0] = bus.dataInE;
    assign w_head[1] = bus.dataInW;
    assign w_head[2] = bus.dataInL;
    assign w_elig    = ~({bus.readFullL, bus.readFullW, bus.readFullE} |
                         {bus.read_almostfullL, bus.read_almostfullW, bus.read_almostfullE});

    // Request matrix and per-output grant selection.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_route[i] = route(w_head[i]);
            w_stv[i]   = (r_wait[i] == LIM);
        end
        for (int o = 0; o < 3; o++) begin
            for (int i = 0; i < 3; i++) begin
                w_req[o][i] = !w_empty[i] && (w_route[i] == 2'(o));
            end
            if (w_elig[o]) begin
                w_gnt[o] = pick(w_req[o], w_stv, r_ptr[o]);
            end else begin
                w_gnt[o] = 3'b000;
            end
        end
        w_granted = w_gnt[0] | w_gnt[1] | w_gnt[2];
    end

    // One-hot data mux from the granted input to each output.
    always_comb begin
        for (int o = 0; o < 3; o++) begin
            w_dout[o] = {WIDTH{1'b0}};
            for (int i = 0; i < 3; i++) begin
                w_dout[o] = w_dout[o] | ({WIDTH{w_gnt[o][i]}} & w_head[i]);
            end
        end
    end

    // Reset gates the outputs directly so they drop without waiting for a clock edge.
    assign bus.readE     = !rst && w_granted[0];
    assign bus.readW     = !rst && w_granted[1];
    assign bus.readL     = !rst && w_granted[2];
    assign bus.writeOutE = !rst && (w_gnt[0] != 3'b000);
    assign bus.writeOutW = !rst && (w_gnt[1] != 3'b000);
    assign bus.writeOutL = !rst && (w_gnt[2] != 3'b000);
    assign bus.dataOutE  = rst ? {WIDTH{1'b0}} : w_dout[0];
    assign bus.dataOutW  = rst ? {WIDTH{1'b0}} : w_dout[1];
    assign bus.dataOutL  = rst ? {WIDTH{1'b0}} : w_dout[2];
    assign bus.starved   = rst ? 3'b000 : w_stv;

    // Round-robin pointers per output and saturating wait counters per input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                r_ptr[k]  <= 2'd0;
                r_wait[k] <= 4'd0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (w_gnt[k] != 3'b000) begin
                    r_ptr[k] <= next_ptr(w_gnt[k]);
                end else begin
                    r_ptr[k] <= r_ptr[k];
                end
                // A non-empty input always requests, so "not granted" means it waited.
                if (w_granted[k] || w_empty[k]) begin
                    r_wait[k] <= 4'd0;
                end else if (r_wait[k] != LIM) begin
                    r_wait[k] <= r_wait[k] + 4'd1;
                end else begin
                    r_wait[k] <= r_wait[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Directed bench for noc_rr_arbiter: queue-backed FIFO heads, a rule-level allocation model
// compared every cycle, and hand-computed literal expectations at the interesting points.
module tb_noc_rr_arbiter;
    localparam int W   = 16;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_rr_arbiter_if #(.WIDTH(W)) bus ();

    noc_rr_arbiter #(.WIDTH(W), .LOCAL_IP(2'b01), .STARVE_LIM(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [15:0] qe[$];
    logic [15:0] qw[$];
    logic [15:0] ql[$];
    logic [15:0] stale [3];
    logic [2:0]  full_v;
    logic [2:0]  af_v;
    int          m_wait [3];
    int          m_ptr  [3];
    int          m_gnt  [3];
    logic [2:0]  x_read, x_wr, x_stv;
    logic [15:0] x_dout [3];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] rr_exp [6] = '{16'h4001, 16'h4011, 16'h4021, 16'h4002, 16'h4012, 16'h4022};

    function automatic bit is_empty(input int i);
        case (i)
            0:       return qe.size() == 0;
            1:       return qw.size() == 0;
            default: return ql.size() == 0;
        endcase
    endfunction

    function automatic logic [15:0] head(input int i);
        if (is_empty(i)) return stale[i];
        case (i)
            0:       return qe[0];
            1:       return qw[0];
            default: return ql[0];
        endcase
    endfunction

    // Destination field vs LOCAL_IP=1: equal -> L(2), above -> E(0), below -> W(1).
    function automatic int route(input logic [15:0] f);
        int d;
        d = int'(f[15:14]);
        if (d == 1) return 2;
        if (d > 1) return 0;
        return 1;
    endfunction

    function automatic bit requests(input int i, input int o);
        return !is_empty(i) && route(head(i)) == o;
    endfunction

    task automatic pop(input int i);
        logic [15:0] t;
        case (i)
            0:       t = qe.pop_front();
            1:       t = qw.pop_front();
            default: t = ql.pop_front();
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        x_read = 3'b000;
        x_wr   = 3'b000;
        x_stv  = 3'b000;
        for (int o = 0; o < 3; o++) begin
            m_gnt[o]  = -1;
            x_dout[o] = 16'h0000;
        end
        if (!rst) begin
            for (int i = 0; i < 3; i++) x_stv[i] = (m_wait[i] == LIM);
            for (int o = 0; o < 3; o++) begin
                if (!full_v[o] && !af_v[o]) begin
                    for (int i = 0; i < 3; i++)
                        if (m_gnt[o] < 0 && requests(i, o) && m_wait[i] == LIM) m_gnt[o] = i;
                    for (int k = 0; k < 3; k++) begin
                        int i;
                        i = (m_ptr[o] + k) % 3;
                        if (m_gnt[o] < 0 && requests(i, o)) m_gnt[o] = i;
                    end
                end
                if (m_gnt[o] >= 0) begin
                    x_wr[o]          = 1'b1;
                    x_read[m_gnt[o]] = 1'b1;
                    x_dout[o]        = head(m_gnt[o]);
                end
            end
        end
    endtask

    task automatic compare_outputs();
        chk("read",     {bus.readL, bus.readW, bus.readE}, x_read);
        chk("writeOut", {bus.writeOutL, bus.writeOutW, bus.writeOutE}, x_wr);
        chk("dataOutE", bus.dataOutE, x_dout[0]);
        chk("dataOutW", bus.dataOutW, x_dout[1]);
        chk("dataOutL", bus.dataOutL, x_dout[2]);
        chk("starved",  bus.starved, x_stv);
    endtask

    task automatic drive_cycle();
        bus.emptyE           = is_empty(0);
        bus.emptyW           = is_empty(1);
        bus.emptyL           = is_empty(2);
        bus.dataInE          = head(0);
        bus.dataInW          = head(1);
        bus.dataInL          = head(2);
        bus.readFullE        = full_v[0];
        bus.readFullW        = full_v[1];
        bus.readFullL        = full_v[2];
        bus.read_almostfullE = af_v[0];
        bus.read_almostfullW = af_v[1];
        bus.read_almostfullL = af_v[2];
        #1;
        model_eval();
        compare_outputs();
    endtask

    task automatic clock();
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_wait[k] = 0;
                m_ptr[k]  = 0;
            end
        end else begin
            for (int o = 0; o < 3; o++)
                if (m_gnt[o] >= 0) m_ptr[o] = (m_gnt[o] + 1) % 3;
            for (int i = 0; i < 3; i++) begin
                if (x_read[i] || is_empty(i)) m_wait[i] = 0;
                else if (m_wait[i] < LIM) m_wait[i] = m_wait[i] + 1;
            end
            for (int i = 0; i < 3; i++)
                if (x_read[i]) pop(i);
        end
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        full_v = 3'b000;
        af_v   = 3'b000;
        for (int k = 0; k < 3; k++) begin
            stale[k]  = 16'h0000;
            m_wait[k] = 0;
            m_ptr[k]  = 0;
        end

        // Reset held with E non-empty, then first grant right after release.
        qe.push_back(16'h4000);
        drive_cycle();
        chk("rst_hold_writeOutL", bus.writeOutL, 1'b0);
        clock();
        rst = 1'b0;
        drive_cycle();
        chk("first_readE", bus.readE, 1'b1);
        chk("first_writeOutL", bus.writeOutL, 1'b1);
        chk("first_dataOutL", bus.dataOutL, 16'h4000);
        clock();

        // Disjoint routes: three transfers in one cycle.
        qe.push_back(16'h8005);
        qw.push_back(16'h0003);
        ql.push_back(16'h4abc);
        drive_cycle();
        chk("route_reads", {bus.readL, bus.readW, bus.readE}, 3'b111);
        chk("route_E", bus.dataOutE, 16'h8005);
        chk("route_W", bus.dataOutW, 16'h0003);
        chk("route_L", bus.dataOutL, 16'h4abc);
        clock();

        // Round-robin on L: E, W, L, E, W, L.
        qe.push_back(16'h4001); qe.push_back(16'h4002);
        qw.push_back(16'h4011); qw.push_back(16'h4012);
        ql.push_back(16'h4021); ql.push_back(16'h4022);
        for (int c = 0; c < 6; c++) begin
            drive_cycle();
            chk("rr_order", bus.dataOutL, rr_exp[c]);
            chk("rr_one_read", 32'($countones({bus.readL, bus.readW, bus.readE})), 32'd1);
            clock();
        end

        // Almost-full backpressure on L for three cycles.
        qe.push_back(16'h4100); qe.push_back(16'h4101);
        qw.push_back(16'h4200);
        af_v = 3'b100;
        for (int c = 0; c < 3; c++) begin
            drive_cycle();
            chk("bp_no_write", bus.writeOutL, 1'b0);
            chk("bp_no_read", {bus.readL, bus.readW, bus.readE}, 3'b000);
            clock();
        end
        chk("bp_model_waitE", m_wait[0], 3);
        chk("bp_model_waitW", m_wait[1], 3);
        af_v = 3'b000;
        drive_cycle();
        chk("bp_resume", bus.dataOutL, 16'h4100);
        chk("bp_not_starved", bus.starved, 3'b000);
        clock();
        drive_cycle();
        chk("bp_W_starved", bus.starved, 3'b010);
        chk("bp_W_override", bus.dataOutL, 16'h4200);
        clock();
        drive_cycle();
        chk("bp_E_second", bus.dataOutL, 16'h4101);
        clock();

        // Starvation: L full for five cycles with E and L requesting L.
        qe.push_back(16'h4300);
        ql.push_back(16'h4500);
        full_v = 3'b100;
        for (int c = 0; c < 5; c++) begin
            drive_cycle();
            if (c == 3) chk("stv_below_lim", bus.starved, 3'b000);
            if (c == 4) chk("stv_at_lim", bus.starved, 3'b101);
            clock();
        end
        full_v = 3'b000;
        drive_cycle();
        chk("stv_tie_E", bus.dataOutL, 16'h4300);
        chk("stv_tie_read", {bus.readL, bus.readW, bus.readE}, 3'b001);
        clock();
        drive_cycle();
        chk("stv_then_L", bus.dataOutL, 16'h4500);
        chk("stv_L_still", bus.starved, 3'b100);
        clock();
        drive_cycle();
        chk("stv_cleared", bus.starved, 3'b000);
        clock();

        // Empty masking with a stale E-bound word on W.
        stale[1] = 16'h8000;
        drive_cycle();
        chk("mask_readW", bus.readW, 1'b0);
        chk("mask_writeOutE", bus.writeOutE, 1'b0);
        clock();
        qw.push_back(16'h8000);
        drive_cycle();
        chk("unmask_dataOutE", bus.dataOutE, 16'h8000);
        clock();

        // Asynchronous reset in the middle of a transfer cycle.
        qe.push_back(16'h4600); qe.push_back(16'h4601);
        qw.push_back(16'h0601); qw.push_back(16'h0602);
        ql.push_back(16'h8601); ql.push_back(16'h8602);
        drive_cycle();
        chk("pre_rst_reads", {bus.readL, bus.readW, bus.readE}, 3'b111);
        rst = 1'b1;
        #1;
        model_eval();
        compare_outputs();
        chk("rst_async_reads", {bus.readL, bus.readW, bus.readE}, 3'b000);
        chk("rst_async_dataOutL", bus.dataOutL, 16'h0000);
        clock();
        drive_cycle();
        clock();
        rst = 1'b0;
        for (int c = 0; c < 10 && (qe.size() + qw.size() + ql.size()) > 0; c++) begin
            drive_cycle();
            clock();
        end
        chk("drain_empty", 32'(qe.size() + qw.size() + ql.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/noc_rr_arbiter.md
# noc_rr_arbiter

Switch allocator for the three-port NoC router (E, W, L). It sits between the three input FIFOs and the registered output stage. Each cycle it decodes the destination field of every FIFO head flit and grants each output port to at most one requesting input, using round-robin with a starvation override. It honours downstream full/almost-full backpressure and pops the granted FIFOs.

## Interface
- WIDTH, 16, flit width in bits; destination field is data[WIDTH-1:WIDTH-2]
- LOCAL_IP, 2'b00, this router's 2-bit address
- STARVE_LIM, 4, wait cycles after which a requester gets priority override (1..15)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- emptyE / emptyW / emptyL  in  1 each  input FIFO empty flags
- dataInE / dataInW / dataInL  in  WIDTH each  input FIFO head flits (show-ahead: valid whenever the matching empty flag is 0)
- readFullE / readFullW / readFullL  in  1 each  downstream FIFO full, per output port
- read_almostfullE / read_almostfullW / read_almostfullL  in  1 each  downstream FIFO almost-full, per output port
- readE / readW / readL  out  1 each  pop strobe to input FIFOs
- writeOutE / writeOutW / writeOutL  out  1 each  write strobe toward output register stage
- dataOutE / dataOutW / dataOutL  out  WIDTH each  flit toward output register stage
- starved  out  3  {L,W,E} per-input flag, 1 while that input's wait counter equals STARVE_LIM

## Operation
- Route function on head flit, d = data[WIDTH-1:WIDTH-2]:
  - d == LOCAL_IP → L
  - d > LOCAL_IP → E
  - d < LOCAL_IP → W
  - No U-turn filtering is done. An E-input flit routed E is legal.
- Request: input i requests output o when empty_i == 0 and route(i) == o. Each input requests exactly one output, so there are no input-side conflicts.
- Output o is eligible when readFull_o == 0 and read_almostfull_o == 0. An ineligible output grants nothing.
- Grant rule per eligible output o, among its requesters:
  - If any requester has wait == STARVE_LIM, grant the lowest-index starved one (index order E=0, W=1, L=2).
  - Otherwise grant round-robin, searching from ptr_o, then ptr_o+1, then ptr_o+2 (mod 3).
- Outputs (combinational from current inputs and state):
  - read_i = 1 iff input i is granted by some output.
  - writeOut_o = 1 iff output o grants.
  - dataOut_o = granted input's head flit, else 0.
- State, per output: 2-bit ptr_o. On a grant to input g, ptr_o ← (g+1) mod 3; otherwise it holds.
- State, per input: wait_i (0..STARVE_LIM), saturating.
  - Cleared when the input is granted or empty.
  - Incremented when the input requests but is not granted. This includes cycles where its output is ineligible.
- Up to three transfers per cycle, one per output, when all routes are disjoint.

## Timing
- Request to grant: 0 cycles, combinational. Pop and ptr/wait update take effect at the next rising edge. The FIFO presents its next head in the following cycle.
- The output register stage adds 1 cycle, and the downstream full flag updates 1 cycle after its write. A grant at cycle t can therefore be followed by one more grant at t+1 before almost_full is visible. Downstream almost_full must assert with ≥2 free entries; with that, overflow never occurs.
- Reset asserted, asynchronously and at any time, including mid-transfer:
  - all ptr_o = 0 and all wait_i = 0;
  - readE/W/L, writeOutE/W/L, and starved are forced to 0;
  - dataOutE/W/L are forced to 0, immediately and without waiting for clk.
- After reset deasserts, the first grant can occur in the first cycle; E has highest round-robin priority.
- A simultaneous starvation tie on one output goes to the lowest index; the other starved inputs stay saturated.
- Empty FIFO: no request and no read, even if the data lines carry stale values.

## Test plan
Use WIDTH=16, LOCAL_IP=2'b01, STARVE_LIM=4.

- **Reset:** assert reset mid-stream with all FIFOs non-empty → all strobes and data 0 in the same cycle; after release, head E=16'h4000 → readE=1, writeOutL=1, dataOutL=16'h4000 in the first cycle.
- **Routing:** E head 16'h8005, W head 16'h0003, L head 16'h4abc, all outputs free → same cycle: writeOutE with 16'h8005, writeOutW with 16'h0003, writeOutL with 16'h4abc; readE/W/L all 1.
- **Round-robin:** E, W and L all hold streams of 16'h4xxx (→L), outputs free → L-port grant order E, W, L, E, W, L over six cycles; one flit per cycle.
- **Backpressure:** read_almostfullL=1 for 3 cycles while E and W request L → no writeOutL and no reads for those cycles; wait counters for E and W reach 3; grants resume in the cycle almost_full drops.
- **Starvation:** hold readFullL=1 for 5 cycles with E and L requesting L → starved[0] and starved[2] go to 1 once their counters reach 4; after release, E (lowest index) is granted first, then L is granted by override; both flags clear on grant.
- **Empty masking:** emptyW=1 with dataInW=16'h8000 → readW=0 and writeOutE=0.
